store_retire_buffer: RTL and testbench
======================================

STORE_RETIRE_BUFFER -- requirements
Module: store_retire_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the number of buffered retired stores (power of two, minimum 2).
REQ-002 The module SHALL have port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port rt_st_valid, input, 1, meaning the retire stage presents one retired store this cycle.
REQ-005 The module SHALL have ports rt_st_addr (input, 64), rt_st_data (input, 64) and rt_st_size (input, MEM_SIZE), carrying that store's byte address, data and size.
REQ-006 The module SHALL have port ld_pending, input, 1, meaning the execute stage has a load waiting on the Dcache.
REQ-007 The module SHALL have port ld_addr, input, 32, giving that load's byte address.
REQ-008 The module SHALL have port dc_write_enable, input, 1, meaning the Dcache controller accepted the store currently presented.
REQ-009 The module SHALL have ports st_en (output, 1), st_addr (output, 64), st_data (output, 64) and st_mem_size (output, MEM_SIZE), forming the store request to the Dcache controller.
REQ-010 The module SHALL have port ld_conflict, output, 1, meaning a buffered store hits the load's 8-byte block and the load must stall.
REQ-011 The module SHALL have ports sq_full and sq_empty, outputs, 1 each, giving buffer occupancy status.
REQ-012 The module SHALL have port sq_count, output, $clog2(DEPTH+1), giving the number of valid entries.
REQ-013 The module SHALL have port overflow_err, output, 1, a sticky flag set when an enqueue is attempted while the buffer is full.

Function
REQ-014 The buffer SHALL be a circular FIFO with head and tail pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 An enqueue SHALL occur iff rt_st_valid is 1 and the registered sq_count is less than DEPTH; the entry SHALL be written at tail and tail SHALL advance by 1.
REQ-016 A full buffer with rt_st_valid=1 SHALL not write an entry, even if a dequeue occurs the same cycle, and SHALL set overflow_err.
REQ-017 sq_full SHALL equal (sq_count==DEPTH) and sq_empty SHALL equal (sq_count==0), both taken from registered state.
REQ-018 sq_count SHALL increment by 1 on enqueue only, decrement by 1 on dequeue only, and stay unchanged on both or neither.
REQ-019 The drain FSM SHALL have three states: IDLE, REQ and GAP.
REQ-020 In IDLE, the FSM SHALL move to REQ iff the buffer is non-empty and NOT (ld_pending AND NOT ld_conflict AND NOT sq_full); a non-stalled load SHALL therefore take priority unless the buffer is full.
REQ-021 In REQ, st_en SHALL be 1 and st_addr/st_data/st_mem_size SHALL equal the head entry, held stable until dc_write_enable is 1.
REQ-022 In REQ with dc_write_enable=1, the head SHALL be dequeued (head+1) that cycle and the FSM SHALL move to GAP.
REQ-023 In GAP, st_en SHALL be 0 for exactly one cycle so the Dcache controller sees an address change; the FSM SHALL then apply the IDLE transition rule.
REQ-024 In IDLE and GAP, st_en SHALL be 0 and st_addr/st_data SHALL still present the head entry, or 0 when the buffer is empty.
REQ-025 ld_conflict SHALL be combinational: 1 iff any valid entry has addr[31:3] equal to ld_addr[31:3] and ld_pending=1, including the entry being written this cycle.
REQ-026 Latency SHALL be as follows: a store enqueued in cycle N into an empty buffer, with FSM in IDLE and no load, SHALL raise st_en in cycle N+1.
REQ-027 Entries SHALL be drained strictly in enqueue order; no entry SHALL be dropped or reordered.

Reset
REQ-028 On reset, head, tail and sq_count SHALL be 0, the FSM SHALL be IDLE, and overflow_err SHALL be 0.
REQ-029 On reset, all entry valid bits SHALL be cleared, giving outputs st_en=0, sq_empty=1, sq_full=0 and ld_conflict=0.
REQ-030 Reset asserted mid-drain, including in REQ awaiting dc_write_enable, SHALL discard all entries with no further st_en assertion.

Verification
REQ-031 Enqueue addr 0x100 data 0xAA, with no load and dc_write_enable=1 one cycle after st_en -> st_en high the next cycle with st_addr=0x100, then GAP, then sq_empty=1.
REQ-032 Enqueue DEPTH stores, then one more -> sq_full=1, the extra store is dropped, overflow_err=1 and stays 1 until reset.
REQ-033 Buffer holds 0x200, ld_pending=1 with ld_addr=0x204 -> ld_conflict=1 and draining proceeds; with ld_addr=0x300 -> ld_conflict=0 and draining waits while the load is pending.
REQ-034 Three stores with dc_write_enable withheld for 5 cycles -> st_addr stays constant while waiting, draining is in order, and st_en drops for one GAP cycle between stores.
REQ-035 Simultaneous enqueue and dequeue at count 3 -> count stays 3 and the pointers wrap correctly across the index DEPTH-1 to 0 boundary.
REQ-036 Reset asserted while in REQ with 4 entries -> the next cycle shows st_en=0, sq_count=0 and no stale store after reset deasserts.

Source files
------------

// File: rtl/store_retire_buffer.sv
// Retired-store buffer: circular FIFO of committed stores drained to the Dcache via an IDLE/REQ/GAP FSM.
// Latency: a store enqueued into an empty, idle buffer with no load pending is requested (st_en) the next cycle.
// Backpressure: a request is held until dc_write_enable; a full buffer drops new stores and sets sticky overflow_err.
module store_retire_buffer #(
  parameter int DEPTH      = 8,
  parameter int MEM_SIZE_W = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rt_st_valid,
  input  logic [63:0]                  rt_st_addr,
  input  logic [63:0]                  rt_st_data,
  input  logic [MEM_SIZE_W-1:0]        rt_st_size,
  input  logic                         ld_pending,
  input  logic [31:0]                  ld_addr,
  input  logic                         dc_write_enable,
  output logic                         st_en,
  output logic [63:0]                  st_addr,
  output logic [63:0]                  st_data,
  output logic [MEM_SIZE_W-1:0]        st_mem_size,
  output logic                         ld_conflict,
  output logic                         sq_full,
  output logic                         sq_empty,
  output logic [$clog2(DEPTH+1)-1:0]   sq_count,
  output logic                         overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef struct packed {
    logic [63:0]           addr;
    logic [63:0]           data;
    logic [MEM_SIZE_W-1:0] size;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             ovf_q, ovf_d;

  logic enq;
  logic deq;
  logic drain_go;
  logic conflict;

  // Occupancy flags come straight from registered count.
  assign sq_full      = (count_q == CNT_W'(DEPTH));
  assign sq_empty     = (count_q == '0);
  assign sq_count     = count_q;
  assign overflow_err = ovf_q;

  // Enqueue is decided on registered occupancy only, so a same-cycle dequeue never frees a slot for a full buffer.
  assign enq = rt_st_valid && (count_q < CNT_W'(DEPTH));
  assign deq = (state_q == ST_REQ) && dc_write_enable;

  // Block-granular (8-byte) address match against every live entry plus the one being written now.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (((ent_q[i].addr[31:0] ^ ld_addr) >> 3) == 32'd0)) begin
        conflict = 1'b1;
      end
    end
    if (enq && (((rt_st_addr[31:0] ^ ld_addr) >> 3) == 32'd0)) begin
      conflict = 1'b1;
    end
  end

  assign ld_conflict = ld_pending && conflict;

  // Start a drain when something is (or is becoming) buffered, unless a non-stalled load owns the Dcache and the
  // buffer still has room; counting the incoming store lets st_en rise the cycle after enqueue.
  assign drain_go = ((count_q != '0) || enq) && !(ld_pending && !ld_conflict && !sq_full);

  // Request fields always track the head entry; zero when the head slot is empty.
  always_comb begin
    st_en       = (state_q == ST_REQ);
    st_addr     = 64'd0;
    st_data     = 64'd0;
    st_mem_size = '0;
    if (vld_q[head_q]) begin
      st_addr     = ent_q[head_q].addr;
      st_data     = ent_q[head_q].data;
      st_mem_size = ent_q[head_q].size;
    end
  end

  // Next-state for storage, pointers, count and the sticky overflow flag.
  always_comb begin
    ent_d   = ent_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    // Head and tail only coincide when empty (no deq) or full (no enq), so clear-then-set never collides.
    if (deq) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
    if (enq) begin
      ent_d[tail_q].addr = rt_st_addr;
      ent_d[tail_q].data = rt_st_data;
      ent_d[tail_q].size = rt_st_size;
      vld_d[tail_q]      = 1'b1;
      tail_d             = tail_q + PTR_W'(1);
    end

    if (enq && !deq) begin
      count_d = count_q + CNT_W'(1);
    end else if (deq && !enq) begin
      count_d = count_q - CNT_W'(1);
    end

    if (rt_st_valid && sq_full) begin
      ovf_d = 1'b1;
    end
  end

  // Drain FSM: REQ holds until accepted, GAP forces one idle cycle so the controller sees a fresh request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = drain_go ? ST_REQ : ST_IDLE;
      ST_REQ:  state_d = dc_write_enable ? ST_GAP : ST_REQ;
      ST_GAP:  state_d = drain_go ? ST_REQ : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state with synchronous reset; reset drops every buffered store.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry payload needs no reset: it is only observed through its valid bit.
  always_ff @(posedge clock) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_store_retire_buffer.sv
module tb_store_retire_buffer;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        rt_st_valid;
  logic [63:0] rt_st_addr;
  logic [63:0] rt_st_data;
  logic [1:0]  rt_st_size;
  logic        ld_pending;
  logic [31:0] ld_addr;
  logic        dc_write_enable;
  logic        st_en;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [1:0]  st_mem_size;
  logic        ld_conflict;
  logic        sq_full;
  logic        sq_empty;
  logic [3:0]  sq_count;
  logic        overflow_err;

  int tests_run = 0;
  int failures  = 0;

  store_retire_buffer #(.DEPTH(DEPTH), .MEM_SIZE_W(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .rt_st_valid     (rt_st_valid),
    .rt_st_addr      (rt_st_addr),
    .rt_st_data      (rt_st_data),
    .rt_st_size      (rt_st_size),
    .ld_pending      (ld_pending),
    .ld_addr         (ld_addr),
    .dc_write_enable (dc_write_enable),
    .st_en           (st_en),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_mem_size     (st_mem_size),
    .ld_conflict     (ld_conflict),
    .sq_full         (sq_full),
    .sq_empty        (sq_empty),
    .sq_count        (sq_count),
    .overflow_err    (overflow_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [63:0] addr, input logic [63:0] data);
    rt_st_valid = 1'b1;
    rt_st_addr  = addr;
    rt_st_data  = data;
    tick();
    rt_st_valid = 1'b0;
  endtask

  // Waits (bounded) for a request, checks it, accepts it, then checks the GAP cycle.
  task automatic drain_one(input string tag, input logic [63:0] exp_addr, input logic [63:0] exp_data);
    int n = 0;
    while (!st_en && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_en"}, {63'd0, st_en}, 64'd1);
    chk({tag, "_addr"}, st_addr, exp_addr);
    chk({tag, "_data"}, st_data, exp_data);
    dc_write_enable = 1'b1;
    tick();
    dc_write_enable = 1'b0;
    chk({tag, "_gap"}, {63'd0, st_en}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rt_st_valid = 1'b0; rt_st_addr = '0; rt_st_data = '0; rt_st_size = 2'd3;
    ld_pending = 1'b0; ld_addr = '0; dc_write_enable = 1'b0;
    tick(); tick();

    // Reset state
    ld_pending = 1'b1; ld_addr = 32'h0;
    #1;
    chk("rst_st_en", {63'd0, st_en}, 64'd0);
    chk("rst_empty", {63'd0, sq_empty}, 64'd1);
    chk("rst_full", {63'd0, sq_full}, 64'd0);
    chk("rst_count", {60'd0, sq_count}, 64'd0);
    chk("rst_ovf", {63'd0, overflow_err}, 64'd0);
    chk("rst_conf", {63'd0, ld_conflict}, 64'd0);
    chk("rst_addr", st_addr, 64'd0);
    ld_pending = 1'b0;
    reset = 1'b0;
    tick();

    // Single store: st_en the cycle after enqueue, accept one cycle later, GAP, empty
    put(64'h100, 64'hAA);
    chk("one_en", {63'd0, st_en}, 64'd1);
    chk("one_addr", st_addr, 64'h100);
    chk("one_data", st_data, 64'hAA);
    chk("one_size", {62'd0, st_mem_size}, 64'd3);
    chk("one_count", {60'd0, sq_count}, 64'd1);
    tick();
    chk("one_hold", {63'd0, st_en}, 64'd1);
    dc_write_enable = 1'b1;
    tick();
    dc_write_enable = 1'b0;
    chk("one_gap", {63'd0, st_en}, 64'd0);
    chk("one_empty", {63'd0, sq_empty}, 64'd1);
    chk("one_gap_addr", st_addr, 64'd0);
    tick();
    chk("one_idle", {63'd0, st_en}, 64'd0);

    // Three stores with write-enable withheld: request stays stable, then in-order drain with GAPs
    put(64'h1000, 64'h11);
    chk("hold_a0", st_addr, 64'h1000);
    put(64'h2000, 64'h22);
    chk("hold_a1", st_addr, 64'h1000);
    put(64'h3000, 64'h33);
    chk("hold_a2", st_addr, 64'h1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_en", {63'd0, st_en}, 64'd1);
      chk("hold_addr", st_addr, 64'h1000);
    end
    chk("hold_count", {60'd0, sq_count}, 64'd3);
    drain_one("three_0", 64'h1000, 64'h11);
    chk("three_gap_head", st_addr, 64'h2000);
    drain_one("three_1", 64'h2000, 64'h22);
    drain_one("three_2", 64'h3000, 64'h33);
    chk("three_empty", {63'd0, sq_empty}, 64'd1);
    tick();

    // Load interaction: non-matching pending load blocks drain, same-block load stalls and lets drain go
    ld_pending = 1'b1; ld_addr = 32'h300;
    put(64'h200, 64'h55);
    #1;
    chk("ld_miss_conf", {63'd0, ld_conflict}, 64'd0);
    chk("ld_miss_wait", {63'd0, st_en}, 64'd0);
    chk("ld_miss_count", {60'd0, sq_count}, 64'd1);
    tick();
    chk("ld_miss_wait2", {63'd0, st_en}, 64'd0);
    ld_addr = 32'h204;
    #1;
    chk("ld_hit_conf", {63'd0, ld_conflict}, 64'd1);
    tick();
    chk("ld_hit_drain", {63'd0, st_en}, 64'd1);
    ld_pending = 1'b0;
    drain_one("ld_hit", 64'h200, 64'h55);
    tick();

    // Simultaneous enqueue+dequeue at count 3 across the pointer wrap (indices 5,6,7 then 0)
    ld_pending = 1'b1; ld_addr = 32'h300;
    put(64'h400, 64'h4);
    put(64'h500, 64'h5);
    put(64'h600, 64'h6);
    chk("wrap_blocked", {63'd0, st_en}, 64'd0);
    ld_pending = 1'b0;
    tick();
    chk("wrap_req", {63'd0, st_en}, 64'd1);
    chk("wrap_cnt3", {60'd0, sq_count}, 64'd3);
    rt_st_valid = 1'b1; rt_st_addr = 64'h700; rt_st_data = 64'h7;
    dc_write_enable = 1'b1;
    tick();
    rt_st_valid = 1'b0; dc_write_enable = 1'b0;
    chk("wrap_both_cnt", {60'd0, sq_count}, 64'd3);
    chk("wrap_both_gap", {63'd0, st_en}, 64'd0);
    chk("wrap_head", st_addr, 64'h500);
    drain_one("wrap_5", 64'h500, 64'h5);
    drain_one("wrap_6", 64'h600, 64'h6);
    drain_one("wrap_7", 64'h700, 64'h7);
    chk("wrap_empty", {63'd0, sq_empty}, 64'd1);
    tick();

    // Overflow: fill with drain blocked, extra store dropped, full buffer overrides the load
    ld_pending = 1'b1; ld_addr = 32'h300;
    for (int i = 0; i < DEPTH; i++) begin
      put(64'h1000 + 64'(i * 8), 64'h80 + 64'(i));
    end
    chk("ovf_full", {63'd0, sq_full}, 64'd1);
    chk("ovf_cnt", {60'd0, sq_count}, 64'd8);
    chk("ovf_pre", {63'd0, overflow_err}, 64'd0);
    put(64'h9990, 64'hDEAD);
    chk("ovf_set", {63'd0, overflow_err}, 64'd1);
    chk("ovf_cnt2", {60'd0, sq_count}, 64'd8);
    chk("ovf_full_drain", {63'd0, st_en}, 64'd1);
    ld_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drain_one("ovf_drain", 64'h1000 + 64'(i * 8), 64'h80 + 64'(i));
    end
    tick(); tick();
    chk("ovf_empty", {63'd0, sq_empty}, 64'd1);
    chk("ovf_no_extra", {63'd0, st_en}, 64'd0);
    chk("ovf_sticky", {63'd0, overflow_err}, 64'd1);

    // Reset while a request is outstanding with 4 entries
    ld_pending = 1'b1; ld_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      put(64'hA000 + 64'(i * 8), 64'hA0 + 64'(i));
    end
    ld_pending = 1'b0;
    tick();
    chk("mid_req", {63'd0, st_en}, 64'd1);
    chk("mid_cnt", {60'd0, sq_count}, 64'd4);
    reset = 1'b1;
    tick();
    chk("mid_rst_en", {63'd0, st_en}, 64'd0);
    chk("mid_rst_cnt", {60'd0, sq_count}, 64'd0);
    chk("mid_rst_ovf", {63'd0, overflow_err}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_en", {63'd0, st_en}, 64'd0);
      chk("post_rst_addr", st_addr, 64'd0);
    end
    chk("post_rst_empty", {63'd0, sq_empty}, 64'd1);

    // Conflict counts the store being written this cycle
    ld_pending = 1'b1; ld_addr = 32'h50C;
    rt_st_valid = 1'b1; rt_st_addr = 64'h508; rt_st_data = 64'h1;
    #1;
    chk("inflight_conf", {63'd0, ld_conflict}, 64'd1);
    rt_st_addr = 64'h510;
    #1;
    chk("inflight_miss", {63'd0, ld_conflict}, 64'd0);
    rt_st_valid = 1'b0; ld_pending = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
